// File: rtl/locked_core_pkg.sv
// Shared types and constants for the key-locked core activation controller:
// FSM states, core widths, LFSR taps, MISR polynomial and fail-count width.
package locked_core_pkg;

    localparam int KEY_W = 16;
    localparam int IN_W  = 41;
    localparam int OUT_W = 32;

    // LFSR shifts left; new bit0 = bit40 ^ bit37
    localparam int LFSR_TAP_A = 40;
    localparam int LFSR_TAP_B = 37;

    // MISR feedback taps: bits 31, 21, 1, 0
    localparam logic [OUT_W-1:0] MISR_POLY = 32'h8020_0003;

    localparam int              FAIL_W   = 2;
    localparam logic [FAIL_W-1:0] FAIL_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_TEST     = 3'd2,
        ST_CHECK    = 3'd3,
        ST_UNLOCKED = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_t;

endpackage

// File: rtl/locked_core_key_ctrl_if.sv
// Signal bundle between the activation controller and its environment
// (key loader, functional user and the locked core itself).
interface locked_core_key_ctrl_if;
    import locked_core_pkg::*;

    logic              start;
    logic              key_bit;
    logic              key_bit_vld;
    logic [IN_W-1:0]   func_in;
    logic [OUT_W-1:0]  core_out;
    logic [IN_W-1:0]   core_in;
    logic [KEY_W-1:0]  key_out;
    logic [OUT_W-1:0]  func_out;
    logic              busy;
    logic              unlocked;
    logic              lockout;
    logic [FAIL_W-1:0] fail_cnt;

    modport slave (
        input  start, key_bit, key_bit_vld, func_in, core_out,
        output core_in, key_out, func_out, busy, unlocked, lockout, fail_cnt
    );

    modport master (
        output start, key_bit, key_bit_vld, func_in, core_out,
        input  core_in, key_out, func_out, busy, unlocked, lockout, fail_cnt
    );

endinterface

// File: rtl/locked_core_key_ctrl_sig_misr.sv
// Multiple-input signature register compacting the core responses during
// self-test; clear has priority over enable.
module sig_misr
    import locked_core_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [OUT_W-1:0] i_data,
    output logic [OUT_W-1:0] o_sig
);

    logic [OUT_W-1:0] r_sig;
    logic             w_fb;

    assign w_fb  = ^(r_sig & MISR_POLY);
    assign o_sig = r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= {r_sig[OUT_W-2:0], w_fb} ^ i_data;
        end
    end

endmodule

// File: rtl/locked_core_key_ctrl.sv
// Activation controller for a key-locked core: serial key load, LFSR/MISR
// self-test, unlock or lockout. Define KEYCTRL_OUTPUT_GATE_EN to gate func_out.
module locked_core_key_ctrl
    import locked_core_pkg::*;
#(
    parameter int               N_PAT      = 64,
    parameter logic [IN_W-1:0]  LFSR_SEED  = 41'h0_0000_0001,
    parameter logic [OUT_W-1:0] GOLDEN_SIG = 32'h0000_0000,
    parameter int               MAX_TRIES  = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    locked_core_key_ctrl_if.slave bus
);

    localparam int PAT_W     = (N_PAT > 1) ? $clog2(N_PAT) : 1;
    localparam int BIT_CNT_W = $clog2(KEY_W);

    state_t            r_state;
    logic [KEY_W-1:0]  r_key_sr;
    logic [KEY_W-1:0]  r_key_out;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [IN_W-1:0]   r_lfsr;
    logic [PAT_W-1:0]  r_pat_cnt;
    logic              r_busy;
    logic              r_unlocked;
    logic              r_lockout;
    logic [FAIL_W-1:0] r_fail_cnt;

    logic              w_start_ok;
    logic [KEY_W-1:0]  w_key_shift;
    logic [IN_W-1:0]   w_lfsr_next;
    logic [FAIL_W-1:0] w_fail_next;
    logic [OUT_W-1:0]  w_sig;

    assign w_start_ok  = bus.start && (r_state == ST_IDLE || r_state == ST_UNLOCKED);
    assign w_key_shift = {bus.key_bit, r_key_sr[KEY_W-1:1]};
    assign w_lfsr_next = {r_lfsr[IN_W-2:0], r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B]};
    assign w_fail_next = (r_fail_cnt == FAIL_MAX) ? r_fail_cnt : r_fail_cnt + 1'b1;

    sig_misr u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_start_ok),
        .i_en   (r_state == ST_TEST),
        .i_data (bus.core_out),
        .o_sig  (w_sig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_key_sr   <= '0;
            r_key_out  <= '0;
            r_bit_cnt  <= '0;
            r_lfsr     <= LFSR_SEED;
            r_pat_cnt  <= '0;
            r_busy     <= 1'b0;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
            r_fail_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_UNLOCKED: begin
                    if (w_start_ok) begin
                        r_state    <= ST_LOAD;
                        r_busy     <= 1'b1;
                        r_key_sr   <= '0;
                        r_key_out  <= '0;
                        r_bit_cnt  <= '0;
                        r_pat_cnt  <= '0;
                        r_unlocked <= 1'b0;
                        r_lfsr     <= LFSR_SEED;
                    end
                end
                ST_LOAD: begin
                    if (bus.key_bit_vld) begin
                        r_key_sr  <= w_key_shift;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        // Key reaches the core only once every bit is in
                        if (r_bit_cnt == BIT_CNT_W'(KEY_W - 1)) begin
                            r_key_out <= w_key_shift;
                            r_state   <= ST_TEST;
                        end
                    end
                end
                ST_TEST: begin
                    r_lfsr    <= w_lfsr_next;
                    r_pat_cnt <= r_pat_cnt + 1'b1;
                    if (r_pat_cnt == PAT_W'(N_PAT - 1)) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_busy <= 1'b0;
                    if (w_sig == GOLDEN_SIG) begin
                        r_state    <= ST_UNLOCKED;
                        r_unlocked <= 1'b1;
                    end else begin
                        r_fail_cnt <= w_fail_next;
                        r_key_out  <= '0;
                        if (w_fail_next == FAIL_W'(MAX_TRIES)) begin
                            r_state   <= ST_LOCKOUT;
                            r_lockout <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    r_lockout <= 1'b1;
                    r_key_out <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_in  = (r_state == ST_TEST) ? r_lfsr : bus.func_in;
    assign bus.key_out  = r_key_out;
    assign bus.busy     = r_busy;
    assign bus.unlocked = r_unlocked;
    assign bus.lockout  = r_lockout;
    assign bus.fail_cnt = r_fail_cnt;

`ifdef KEYCTRL_OUTPUT_GATE_EN
    assign bus.func_out = r_unlocked ? bus.core_out : '0;
`else
    assign bus.func_out = bus.core_out;
`endif

endmodule

// File: tb/tb_locked_core_key_ctrl.sv
// Directed bench for locked_core_key_ctrl: models the locked core, the LFSR
// and the MISR to derive the golden signature and the expected outcomes.
module tb_locked_core_key_ctrl;
    import locked_core_pkg::*;

    localparam int               N_PAT   = 24;
    localparam logic [IN_W-1:0]  SEED    = 41'h0A5_C3E1_7B29;
    localparam logic [KEY_W-1:0] GOODKEY = 16'hBEA4;

    // Locked-core model: transparent mixing only with the correct key
    function automatic logic [OUT_W-1:0] core_f(input logic [IN_W-1:0] ci, input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] d;
        d = k ^ 16'hBEA4;
        return ci[31:0] ^ {ci[40:32], 23'd0} ^ {d, d};
    endfunction

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] l);
        return {l[39:0], l[40] ^ l[37]};
    endfunction

    function automatic logic [OUT_W-1:0] calc_sig(input logic [KEY_W-1:0] k);
        logic [IN_W-1:0]  l;
        logic [OUT_W-1:0] m;
        l = SEED;
        m = '0;
        for (int i = 0; i < N_PAT; i++) begin
            m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ core_f(l, k);
            l = lfsr_step(l);
        end
        return m;
    endfunction

    localparam logic [OUT_W-1:0] GOLDEN = calc_sig(16'hBEA4);

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [FAIL_W-1:0] exp_fail;

    locked_core_key_ctrl_if bus();

    assign bus.core_out = core_f(bus.core_in, bus.key_out);

    locked_core_key_ctrl #(
        .N_PAT      (N_PAT),
        .LFSR_SEED  (SEED),
        .GOLDEN_SIG (GOLDEN),
        .MAX_TRIES  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] exp_func_out(input logic [IN_W-1:0] fi, input logic [KEY_W-1:0] k,
                                                       input logic unl);
`ifdef KEYCTRL_OUTPUT_GATE_EN
        return unl ? core_f(fi, k) : '0;
`else
        if (unl) return core_f(fi, k);
        return core_f(fi, k);
`endif
    endfunction

    // Full activation: start, 16 key bits, then follow TEST/CHECK
    task automatic activate(input logic [KEY_W-1:0] k, input bit inj_start);
        int              busy_cnt;
        int              p;
        int              guard;
        logic            pass;
        logic [IN_W-1:0] ml;
        pass     = (calc_sig(k) == GOLDEN);
        busy_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", 64'(bus.busy), 64'd1);
        chk("start_unlocked_drop", 64'(bus.unlocked), 64'd0);
        chk("start_key_clear", 64'(bus.key_out), 64'd0);
        for (int i = 0; i < KEY_W; i++) begin
            bus.key_bit     = k[i];
            bus.key_bit_vld = 1'b1;
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (i == KEY_W - 1) chk("load_key_hidden", 64'(bus.key_out), 64'd0);
            tick();
        end
        bus.key_bit_vld = 1'b0;
        bus.key_bit     = 1'b0;
        ml    = SEED;
        p     = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 500) begin
            @(negedge clk);
            busy_cnt++;
            if (p == 0) chk("test_key_out", 64'(bus.key_out), 64'(k));
            if (p < N_PAT) begin
                chk("test_core_in", 64'(bus.core_in), 64'(ml));
                ml = lfsr_step(ml);
            end
            p++;
            bus.start = inj_start && (p == 3);
            tick();
            guard++;
        end
        bus.start = 1'b0;
        chk("busy_len", 64'(busy_cnt), 64'(KEY_W + N_PAT + 1));
        if (pass) begin
            chk("pass_unlocked", 64'(bus.unlocked), 64'd1);
            chk("pass_key_out", 64'(bus.key_out), 64'(k));
        end else begin
            if (exp_fail != FAIL_MAX) exp_fail = exp_fail + 1'b1;
            chk("fail_unlocked", 64'(bus.unlocked), 64'd0);
            chk("fail_key_out", 64'(bus.key_out), 64'd0);
        end
        chk("fail_cnt", 64'(bus.fail_cnt), 64'(exp_fail));
        chk("lockout", 64'(bus.lockout), 64'(exp_fail == 2'd3));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_fail = '0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.key_bit     = 1'b0;
        bus.key_bit_vld = 1'b0;
        bus.func_in     = 41'h1_2345_6789A;
        tick();
        tick();
        // Reset state
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_unlocked", 64'(bus.unlocked), 64'd0);
        chk("rst_lockout", 64'(bus.lockout), 64'd0);
        chk("rst_fail_cnt", 64'(bus.fail_cnt), 64'd0);
        chk("rst_key_out", 64'(bus.key_out), 64'd0);
        chk("rst_core_in", 64'(bus.core_in), 64'(bus.func_in));
        rst_n = 1'b1;
        tick();

        // Correct key unlocks
        activate(GOODKEY, 1'b0);

        // Functional pass-through after unlock
        for (int i = 0; i < 10; i++) begin
            bus.func_in = {9'($urandom), 32'($urandom)};
            #1;
            chk("func_core_in", 64'(bus.core_in), 64'(bus.func_in));
            chk("func_out", 64'(bus.func_out), 64'(exp_func_out(bus.func_in, GOODKEY, 1'b1)));
            tick();
        end

        // Stray key bits while not loading are ignored
        for (int i = 0; i < 5; i++) begin
            bus.key_bit     = 1'b1;
            bus.key_bit_vld = 1'b1;
            tick();
        end
        bus.key_bit_vld = 1'b0;
        chk("stray_key_out", 64'(bus.key_out), 64'(GOODKEY));
        chk("stray_busy", 64'(bus.busy), 64'd0);

        // Re-run with start pulsed during TEST
        activate(GOODKEY, 1'b1);

        // Wrong key fails back to IDLE
        activate(16'h0000, 1'b0);
        #1;
        chk("idle_func_out", 64'(bus.func_out), 64'(exp_func_out(bus.func_in, 16'h0000, 1'b0)));
        for (int i = 0; i < 3; i++) begin
            bus.key_bit     = 1'b1;
            bus.key_bit_vld = 1'b1;
            tick();
        end
        bus.key_bit_vld = 1'b0;
        chk("idle_stray_key", 64'(bus.key_out), 64'd0);
        chk("idle_stray_busy", 64'(bus.busy), 64'd0);

        // Two more wrong keys reach lockout
        activate(16'h1234, 1'b0);
        activate(16'hBEA5, 1'b0);

        // Lockout ignores start and key bits
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
            bus.key_bit     = GOODKEY[i];
            bus.key_bit_vld = 1'b1;
            tick();
            chk("lock_busy", 64'(bus.busy), 64'd0);
        end
        bus.key_bit_vld = 1'b0;
        chk("lock_lockout", 64'(bus.lockout), 64'd1);
        chk("lock_key_out", 64'(bus.key_out), 64'd0);
        chk("lock_unlocked", 64'(bus.unlocked), 64'd0);
        chk("lock_fail_cnt", 64'(bus.fail_cnt), 64'd3);

        // Asynchronous reset in the middle of LOAD
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_fail = '0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.key_bit     = GOODKEY[i];
            bus.key_bit_vld = 1'b1;
            tick();
        end
        bus.key_bit_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_key_out", 64'(bus.key_out), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_lockout", 64'(bus.lockout), 64'd0);
        chk("arst_fail_cnt", 64'(bus.fail_cnt), 64'd0);
        chk("arst_core_in", 64'(bus.core_in), 64'(bus.func_in));
        tick();
        rst_n = 1'b1;
        tick();
        activate(GOODKEY, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
